// File: rtl/bin2dec_7seg_driver.sv
// Sequential binary-to-decimal converter with 7-segment encoding.
// Converts one bit per clock with double-dabble, then publishes BCD digits,
// segment patterns, overflow and sign together in a single update cycle.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - conversion request, sampled only while idle
//   value     - binary operand, captured on the accepted start cycle
//   busy      - conversion in progress
//   done      - one-cycle pulse when the outputs update
//   ovf       - magnitude does not fit in NUM_DIGITS decimal digits
//   neg       - signed mode and captured value negative
//   bcd       - BCD digits, digit 0 at [3:0]
//   segs      - active-low {dp,g,f,e,d,c,b,a} per digit, digit 0 at [7:0]
//   seg_sign  - minus pattern when neg, blank otherwise
module bin2dec_7seg_driver #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_DIGITS  = 3,
  parameter bit          SIGNED_MODE = 1'b0,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   value,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic                    neg,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [8*NUM_DIGITS-1:0] segs,
  output logic [7:0]              seg_sign
);

  // Enough internal digits for the full unsigned range, and never fewer
  // than the displayed digit count so the low slice always exists.
  localparam int unsigned INT_DIGITS = (DATA_WIDTH * 3) / 10 + 1;
  localparam int unsigned ACC_DIGITS = (INT_DIGITS > NUM_DIGITS) ? INT_DIGITS : NUM_DIGITS;
  localparam int unsigned ACC_W      = 4 * ACC_DIGITS;
  localparam int unsigned CNT_W      = $clog2(DATA_WIDTH + 1);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_UPD
  } state_t;

  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sign_q, sign_d;

  logic                    busy_d, done_d, ovf_d, neg_d;
  logic [4*NUM_DIGITS-1:0] bcd_d;
  logic [8*NUM_DIGITS-1:0] segs_d;
  logic [7:0]              seg_sign_d;

  logic                    neg_in;
  logic [DATA_WIDTH-1:0]   mag;
  logic [ACC_W-1:0]        adj;
  logic                    hi_nz;
  logic                    nz_seen;
  logic [3:0]              dig;

  // Digit to active-low segment pattern, decimal point off.
  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [ACC_W-1:0] dabble_adjust(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < int'(ACC_DIGITS); i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Magnitude of the operand; unsigned negate keeps -2^(W-1) exact.
  assign neg_in = SIGNED_MODE && value[DATA_WIDTH-1];
  assign mag    = neg_in ? (~value + DATA_WIDTH'(1)) : value;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    busy_d     = busy;
    done_d     = 1'b0;
    ovf_d      = ovf;
    neg_d      = neg;
    bcd_d      = bcd;
    segs_d     = segs;
    seg_sign_d = seg_sign;
    adj        = '0;
    hi_nz      = 1'b0;
    nz_seen    = 1'b0;
    dig        = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = mag;
          acc_d   = '0;
          sign_d  = neg_in;
          cnt_d   = CNT_W'(DATA_WIDTH);
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end

      S_CONV: begin
        adj            = dabble_adjust(acc_q);
        {acc_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_UPD;
      end

      S_UPD: begin
        for (int i = int'(NUM_DIGITS); i < int'(ACC_DIGITS); i++) begin
          hi_nz = hi_nz | (acc_q[4*i +: 4] != 4'd0);
        end
        ovf_d = hi_nz;
        bcd_d = acc_q[4*NUM_DIGITS-1:0];
        // Walk from the top digit down; blank until the first nonzero digit.
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
          dig     = acc_q[4*i +: 4];
          nz_seen = nz_seen | (dig != 4'd0);
          if (hi_nz)
            segs_d[8*i +: 8] = SEG_DASH;
          else if (BLANK_LZ && !nz_seen && (i != 0))
            segs_d[8*i +: 8] = SEG_BLANK;
          else
            segs_d[8*i +: 8] = seg_encode(dig);
        end
        // A zero magnitude never shows a minus sign.
        neg_d      = sign_q && (acc_q != '0);
        seg_sign_d = neg_d ? SEG_DASH : SEG_BLANK;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      neg      <= 1'b0;
      bcd      <= '0;
      segs     <= '1;
      seg_sign <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      busy     <= busy_d;
      done     <= done_d;
      ovf      <= ovf_d;
      neg      <= neg_d;
      bcd      <= bcd_d;
      segs     <= segs_d;
      seg_sign <= seg_sign_d;
    end
  end

endmodule

// File: tb/tb_bin2dec_7seg_driver.sv
// Scoreboard bench for bin2dec_7seg_driver: four configurations share clock,
// reset and operand; each has its own start, expected queue and monitor.
module tb_bin2dec_7seg_driver;

  typedef struct {
    logic [39:0] bcd;
    logic [79:0] segs;
    logic [7:0]  sign;
    logic        ovf;
    logic        neg;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v;
  logic [31:0] value;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic busy0, done0, ovf0, neg0; logic [11:0] bcd0; logic [23:0] segs0; logic [7:0] sign0;
  logic busy1, done1, ovf1, neg1; logic [11:0] bcd1; logic [23:0] segs1; logic [7:0] sign1;
  logic busy2, done2, ovf2, neg2; logic [39:0] bcd2; logic [79:0] segs2; logic [7:0] sign2;
  logic busy3, done3, ovf3, neg3; logic [11:0] bcd3; logic [23:0] segs3; logic [7:0] sign3;

  exp_t q0[$], q1[$], q2[$], q3[$];
  exp_t m0, m1, m2, m3;
  logic [11:0] last_bcd0;
  logic [23:0] last_segs0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: unsigned, 3 digits, blanking
  bin2dec_7seg_driver #(.DATA_WIDTH(32), .NUM_DIGITS(3), .SIGNED_MODE(1'b0), .BLANK_LZ(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .value(value), .busy(busy0), .done(done0),
    .ovf(ovf0), .neg(neg0), .bcd(bcd0), .segs(segs0), .seg_sign(sign0));
  // u1: signed, 3 digits, blanking
  bin2dec_7seg_driver #(.DATA_WIDTH(32), .NUM_DIGITS(3), .SIGNED_MODE(1'b1), .BLANK_LZ(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .value(value), .busy(busy1), .done(done1),
    .ovf(ovf1), .neg(neg1), .bcd(bcd1), .segs(segs1), .seg_sign(sign1));
  // u2: signed, 10 digits, blanking
  bin2dec_7seg_driver #(.DATA_WIDTH(32), .NUM_DIGITS(10), .SIGNED_MODE(1'b1), .BLANK_LZ(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .value(value), .busy(busy2), .done(done2),
    .ovf(ovf2), .neg(neg2), .bcd(bcd2), .segs(segs2), .seg_sign(sign2));
  // u3: unsigned, 3 digits, no blanking
  bin2dec_7seg_driver #(.DATA_WIDTH(32), .NUM_DIGITS(3), .SIGNED_MODE(1'b0), .BLANK_LZ(1'b0)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .value(value), .busy(busy3), .done(done3),
    .ovf(ovf3), .neg(neg3), .bcd(bcd3), .segs(segs3), .seg_sign(sign3));

  task automatic chk(input int idx, input string name, input logic [79:0] act, input logic [79:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL u%0d %s: got %h expected %h", idx, name, act, req);
    end
  endtask

  task automatic unexpected(input int idx);
    n_checks++;
    n_fail++;
    $display("FAIL u%0d unexpected_done: got done=1 expected no pending result at cycle %0d", idx, cyc);
  endtask

  task automatic score(input int idx, input exp_t e, input logic [39:0] b, input logic [79:0] s,
                       input logic [7:0] sg, input logic o, input logic n);
    chk(idx, "bcd", 80'(b), 80'(e.bcd));
    chk(idx, "segs", s, e.segs);
    chk(idx, "seg_sign", 80'(sg), 80'(e.sign));
    chk(idx, "ovf", 80'(o), 80'(e.ovf));
    chk(idx, "neg", 80'(n), 80'(e.neg));
    chk(idx, "done_cycle", 80'(cyc), 80'(e.cyc));
  endtask

  function automatic exp_t mk(input logic [39:0] b, input logic [79:0] s, input logic [7:0] sg,
                              input logic o, input logic n);
    exp_t e;
    e.bcd = b; e.segs = s; e.sign = sg; e.ovf = o; e.neg = n; e.cyc = 0;
    return e;
  endfunction

  function automatic int qsize(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic push(input int idx, input exp_t e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic drain(input int idx, input int budget);
    for (int k = 0; k < budget && qsize(idx) != 0; k++) @(negedge clk);
    chk(idx, "drain_pending", 80'(qsize(idx)), 80'(0));
  endtask

  // Single conversion: start applied at a negedge, accepted on the next edge.
  task automatic run(input int idx, input logic [31:0] v, input exp_t e0);
    exp_t e;
    e = e0;
    @(negedge clk);
    value        = v;
    start_v[idx] = 1'b1;
    e.cyc        = cyc + 34;
    push(idx, e);
    @(negedge clk);
    start_v[idx] = 1'b0;
    drain(idx, 60);
    repeat (3) @(negedge clk);
  endtask

  // Monitors: pop and compare on each done pulse.
  always @(negedge clk) begin
    if (rst) begin
      last_bcd0  = '0;
      last_segs0 = '1;
    end else if (done0 === 1'b1) begin
      if (q0.size() == 0) unexpected(0);
      else begin
        m0 = q0.pop_front();
        score(0, m0, 40'(bcd0), 80'(segs0), sign0, ovf0, neg0);
      end
      last_bcd0  = bcd0;
      last_segs0 = segs0;
    end else if (busy0 === 1'b1) begin
      chk(0, "hold_bcd", 80'(bcd0), 80'(last_bcd0));
      chk(0, "hold_segs", 80'(segs0), 80'(last_segs0));
    end
  end

  always @(negedge clk) begin
    if (!rst && done1 === 1'b1) begin
      if (q1.size() == 0) unexpected(1);
      else begin
        m1 = q1.pop_front();
        score(1, m1, 40'(bcd1), 80'(segs1), sign1, ovf1, neg1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2 === 1'b1) begin
      if (q2.size() == 0) unexpected(2);
      else begin
        m2 = q2.pop_front();
        score(2, m2, bcd2, segs2, sign2, ovf2, neg2);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done3 === 1'b1) begin
      if (q3.size() == 0) unexpected(3);
      else begin
        m3 = q3.pop_front();
        score(3, m3, 40'(bcd3), 80'(segs3), sign3, ovf3, neg3);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst     = 1'b1;
    start_v = '0;
    value   = '0;
    repeat (3) @(negedge clk);

    chk(0, "rst_busy", 80'(busy0), 80'(0));
    chk(0, "rst_done", 80'(done0), 80'(0));
    chk(0, "rst_ovf", 80'(ovf0), 80'(0));
    chk(0, "rst_neg", 80'(neg0), 80'(0));
    chk(0, "rst_bcd", 80'(bcd0), 80'(0));
    chk(0, "rst_segs", 80'(segs0), 80'(24'hFFFFFF));
    chk(0, "rst_sign", 80'(sign0), 80'(8'hFF));
    chk(2, "rst_segs", segs2, {80{1'b1}});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 32'd23,   mk(40'h023, 80'hFFA4B0, 8'hFF, 1'b0, 1'b0));
    run(0, 32'd1000, mk(40'h000, 80'hBFBFBF, 8'hFF, 1'b1, 1'b0));
    run(0, 32'd999,  mk(40'h999, 80'h909090, 8'hFF, 1'b0, 1'b0));

    // Extra start pulses mid-conversion must be ignored.
    @(negedge clk);
    value = 32'd5; start_v[0] = 1'b1;
    push(0, mk(40'h005, 80'hFFFF92, 8'hFF, 1'b0, 1'b0));
    q0[0].cyc = cyc + 34;
    @(negedge clk);
    start_v[0] = 1'b0; value = 32'd77;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (14) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    drain(0, 60);
    repeat (40) @(negedge clk);

    // Start held high: back-to-back results every 34 cycles.
    @(negedge clk);
    value = 32'd42; start_v[0] = 1'b1;
    c = cyc;
    for (int k = 1; k <= 3; k++) begin
      push(0, mk(40'h042, 80'hFF99A4, 8'hFF, 1'b0, 1'b0));
      q0[k-1].cyc = c + 34 * k;
    end
    for (int k = 0; k < 120 && q0.size() > 1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    start_v[0] = 1'b0;
    drain(0, 60);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    value = 32'd123; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk(0, "mid_rst_busy", 80'(busy0), 80'(0));
    chk(0, "mid_rst_segs", 80'(segs0), 80'(24'hFFFFFF));
    chk(0, "mid_rst_bcd", 80'(bcd0), 80'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    run(0, 32'd7, mk(40'h007, 80'hFFFFF8, 8'hFF, 1'b0, 1'b0));
    run(3, 32'd7, mk(40'h007, 80'hC0C0F8, 8'hFF, 1'b0, 1'b0));
    run(3, 32'd0, mk(40'h000, 80'hC0C0C0, 8'hFF, 1'b0, 1'b0));

    run(1, 32'hFFFFFFFB, mk(40'h005, 80'hFFFF92, 8'hBF, 1'b0, 1'b1));
    run(1, 32'h00000000, mk(40'h000, 80'hFFFFC0, 8'hFF, 1'b0, 1'b0));
    run(1, 32'hFFFFFC18, mk(40'h000, 80'hBFBFBF, 8'hBF, 1'b1, 1'b1));

    run(2, 32'h80000000, mk(40'h2147483648, 80'hA4F999F89980B0829980, 8'hBF, 1'b0, 1'b1));
    run(2, 32'd123,      mk(40'h0000000123, 80'hFFFFFFFFFFFFFFF9A4B0, 8'hFF, 1'b0, 1'b0));

    repeat (40) @(negedge clk);
    chk(0, "final_queue", 80'(q0.size()), 80'(0));
    chk(1, "final_queue", 80'(q1.size()), 80'(0));
    chk(2, "final_queue", 80'(q2.size()), 80'(0));
    chk(3, "final_queue", 80'(q3.size()), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
